// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_param
// Description : Serial pattern detector with a runtime-loadable pattern,
//               overlapping/non-overlapping modes and an optional saturating
//               hit counter (enabled by defining HIT_COUNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
  parameter int               PAT_W       = 3,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = {PAT_W{1'b1}},
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ina,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             dataout,
  output logic             hit_pulse
`ifdef HIT_COUNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_count
`endif
);

  localparam int                FILL_W      = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] C_FILL_MAX  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ARMED = 2'd1,
    ST_MATCH = 2'd2
  } state_t;

  if (PAT_W < 2) begin : g_pat_w_check
    $error("seq_detect_param: PAT_W must be >= 2");
  end

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("seq_detect_param: CNT_W must be >= 1");
  end

  state_t            r_state;
  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-2:0]  r_sh;
  logic [FILL_W-1:0] r_fill;

  logic [PAT_W-1:0]  w_win;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_full;
  logic              w_hit;

  assign w_win      = {r_sh, ina};
  assign w_full     = (r_fill >= C_FILL_FULL);
  assign w_fill_inc = (r_fill == C_FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
  // A load strobe discards the current sample, so it can never produce a hit.
  assign w_hit      = en && !pat_load && w_full && (w_win == r_pat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat     <= PAT_DEFAULT;
      r_sh      <= '0;
      r_fill    <= '0;
      r_state   <= ST_FILL;
      dataout   <= 1'b0;
      hit_pulse <= 1'b0;
    end else if (pat_load) begin
      r_pat     <= pat_in;
      r_sh      <= '0;
      r_fill    <= '0;
      r_state   <= ST_FILL;
      dataout   <= 1'b0;
      hit_pulse <= 1'b0;
    end else if (en) begin
      hit_pulse <= w_hit;
      if (w_hit && !overlap) begin
        // Non-overlapping: restart collection so the next hit needs PAT_W fresh bits.
        r_sh    <= '0;
        r_fill  <= '0;
        r_state <= ST_MATCH;
        dataout <= 1'b1;
      end else begin
        r_sh   <= w_win[PAT_W-2:0];
        r_fill <= w_fill_inc;
        if (w_hit) begin
          r_state <= ST_MATCH;
          dataout <= 1'b1;
        end else if (r_state == ST_MATCH && !overlap) begin
          r_state <= ST_FILL;
          dataout <= 1'b0;
        end else if (w_fill_inc >= C_FILL_FULL) begin
          r_state <= ST_ARMED;
          dataout <= 1'b0;
        end else begin
          r_state <= ST_FILL;
          dataout <= 1'b0;
        end
      end
    end else begin
      hit_pulse <= 1'b0;
    end
  end

`ifdef HIT_COUNT_EN
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count <= '0;
    end else if (cnt_clr) begin
      hit_count <= '0;
    end else if (w_hit && hit_count != C_CNT_MAX) begin
      hit_count <= hit_count + CNT_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire
